// File: rtl/versat_accum_pkg.sv
// Shared definitions for the Versat windowed-reduction accumulator: op encodings and
// a width-generic saturating adder.
package versat_accum_pkg;

  localparam logic [1:0] OP_MAX = 2'b00;
  localparam logic [1:0] OP_MIN = 2'b01;
  localparam logic [1:0] OP_SUM = 2'b10;

  // Widest datapath sat_add supports; operands live in the low data_w bits.
  localparam int unsigned SAT_MAX_W = 32;

  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input logic              is_signed,
                                                   input int unsigned       data_w);
    logic [SAT_MAX_W:0]   sum;
    logic [SAT_MAX_W-1:0] mask;
    logic [SAT_MAX_W-1:0] pos_max;
    logic [SAT_MAX_W-1:0] neg_min;
    mask    = (data_w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << data_w) - SAT_MAX_W'(1));
    sum     = {1'b0, a & mask} + {1'b0, b & mask};
    pos_max = mask >> 1;
    neg_min = pos_max + SAT_MAX_W'(1);
    if (is_signed) begin
      // Overflow only when both operands share a sign that the result lacks.
      if ((a[data_w-1] == b[data_w-1]) && (sum[data_w-1] != a[data_w-1])) begin
        return a[data_w-1] ? neg_min : pos_max;
      end
      return sum[SAT_MAX_W-1:0] & mask;
    end
    if (sum[data_w]) begin
      return mask;
    end
    return sum[SAT_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/accum_reduce_alu.sv
// Combinational reduction step: picks the next accumulator value from the running
// result and the incoming sample.
module accum_reduce_alu
  import versat_accum_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_in,
  input  logic [1:0]        i_op,
  input  logic              i_is_signed,
  input  logic              i_first,
  output logic [DATA_W-1:0] o_acc_next
);

  logic w_acc_lt_in;

  always_comb begin
    w_acc_lt_in = i_is_signed ? ($signed(i_acc) < $signed(i_in)) : (i_acc < i_in);
    o_acc_next  = i_in;
    if (!i_first) begin
      case (i_op)
        OP_MIN:  o_acc_next = w_acc_lt_in ? i_acc : i_in;
        OP_SUM:  o_acc_next = DATA_W'(sat_add(SAT_MAX_W'(i_acc), SAT_MAX_W'(i_in),
                                              i_is_signed, DATA_W));
        // Reserved encoding behaves as max.
        default: o_acc_next = w_acc_lt_in ? i_in : i_acc;
      endcase
    end
  end

endmodule

// File: rtl/f_accum_reduce.sv
// Windowed max/min/saturating-sum reducer with a start delay and an end-of-window flag.
// Counters, captured configuration and output registers live here.
module f_accum_reduce
  import versat_accum_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DELAY_W  = 7,
  parameter int unsigned STRIDE_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                running,
  input  logic [1:0]          op,
  input  logic                isSigned,
  input  logic [STRIDE_W-1:0] strideMinusOne,
  input  logic [DELAY_W-1:0]  delay0,
  input  logic [DATA_W-1:0]   in0,
  output logic [DATA_W-1:0]   out0,
  output logic                windowEnd
);

  logic [1:0]          r_op;
  logic                r_is_signed;
  logic [STRIDE_W-1:0] r_stride;
  logic [DELAY_W-1:0]  r_delay_cnt;
  logic [STRIDE_W-1:0] r_win_cnt;
  logic [DATA_W-1:0]   r_acc;
  logic                r_win_end;

  logic                w_first;
  logic                w_last;
  logic [DATA_W-1:0]   w_acc_next;

  assign w_first = (r_win_cnt == '0);
  assign w_last  = (r_win_cnt == r_stride);

  accum_reduce_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_acc       (r_acc),
    .i_in        (in0),
    .i_op        (r_op),
    .i_is_signed (r_is_signed),
    .i_first     (w_first),
    .o_acc_next  (w_acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_is_signed <= 1'b0;
      r_stride    <= '0;
      r_delay_cnt <= '0;
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_win_end   <= 1'b0;
    end else if (run) begin
      // Restart discards any partial window; out0 keeps its last value.
      r_op        <= op;
      r_is_signed <= isSigned;
      r_stride    <= strideMinusOne;
      r_delay_cnt <= delay0;
      r_win_cnt   <= '0;
      r_win_end   <= 1'b0;
    end else if (running) begin
      if (r_delay_cnt != '0) begin
        r_delay_cnt <= r_delay_cnt - DELAY_W'(1);
        r_win_end   <= 1'b0;
      end else begin
        r_acc     <= w_acc_next;
        r_win_end <= w_last;
        r_win_cnt <= w_last ? '0 : r_win_cnt + STRIDE_W'(1);
      end
    end else begin
      r_win_end <= 1'b0;
    end
  end

  assign out0      = r_acc;
  assign windowEnd = r_win_end;

endmodule

// File: tb/tb_f_accum_reduce.sv
// Directed bench for f_accum_reduce: hand-computed vectors per feature plus a swept
// comparison against a small behavioural model.
module tb_f_accum_reduce;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       running;
  logic [1:0] op;
  logic       is_signed;
  logic [6:0] stride;
  logic [6:0] delay;
  logic [7:0] in0;
  logic [7:0] out0;
  logic       window_end;

  int checks   = 0;
  int failures = 0;

  f_accum_reduce dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .running        (running),
    .op             (op),
    .isSigned       (is_signed),
    .strideMinusOne (stride),
    .delay0         (delay),
    .in0            (in0),
    .out0           (out0),
    .windowEnd      (window_end)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] o, input logic s, input logic [6:0] st,
                       input logic [6:0] d);
    op        = o;
    is_signed = s;
    stride    = st;
    delay     = d;
    run       = 1'b1;
    running   = 1'b0;
    tick();
    run = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    run       = 1'(($urandom) & 1);
    running   = 1'(($urandom) & 1);
    op        = 2'($urandom);
    is_signed = 1'($urandom);
    stride    = 7'($urandom);
    delay     = 7'($urandom);
    in0       = 8'($urandom);
    #2;
    checks += 2;
    if (out0 !== 8'h00) begin
      failures++;
      $display("FAIL reset_out0 got=%h exp=00", out0);
    end
    if (window_end !== 1'b0) begin
      failures++;
      $display("FAIL reset_we got=%b exp=0", window_end);
    end
    run     = 1'b0;
    running = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in0 = 8'($urandom);
      tick();
      checks++;
      if (out0 !== 8'h00 || window_end !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got=%h/%b exp=00/0", i, out0, window_end);
      end
    end
  endtask

  task automatic test_signed_max();
    logic [7:0] smp [8];
    logic [7:0] exp [8];
    logic       we  [8];
    smp = '{8'h05, 8'hFD, 8'h07, 8'h02, 8'hF8, 8'hFF, 8'hF7, 8'hFE};
    exp = '{8'h05, 8'h05, 8'h07, 8'h07, 8'hF8, 8'hFF, 8'hFF, 8'hFF};
    we  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    start(2'b00, 1'b1, 7'd3, 7'd0);
    checks++;
    if (out0 !== 8'h00 || window_end !== 1'b0) begin
      failures++;
      $display("FAIL max_run_edge got=%h/%b exp=00/0", out0, window_end);
    end
    for (int i = 0; i < 8; i++) begin
      running = 1'b1;
      in0     = smp[i];
      tick();
      checks += 2;
      if (out0 !== exp[i]) begin
        failures++;
        $display("FAIL max_out0 idx=%0d got=%h exp=%h", i, out0, exp[i]);
      end
      if (window_end !== we[i]) begin
        failures++;
        $display("FAIL max_we idx=%0d got=%b exp=%b", i, window_end, we[i]);
      end
    end
    running = 1'b0;
  endtask

  task automatic test_unsigned_min_delay();
    logic [7:0] dly [2];
    logic [7:0] smp [4];
    logic [7:0] exp [4];
    logic       we  [4];
    dly = '{8'hF0, 8'hE0};
    smp = '{8'h10, 8'h80, 8'hFF, 8'h01};
    exp = '{8'h10, 8'h10, 8'hFF, 8'h01};
    we  = '{1'b0, 1'b1, 1'b0, 1'b1};
    start(2'b01, 1'b0, 7'd1, 7'd2);
    for (int i = 0; i < 2; i++) begin
      running = 1'b1;
      in0     = dly[i];
      tick();
      checks++;
      if (out0 !== 8'hFF || window_end !== 1'b0) begin
        failures++;
        $display("FAIL min_delay idx=%0d got=%h/%b exp=ff/0", i, out0, window_end);
      end
    end
    for (int i = 0; i < 4; i++) begin
      in0 = smp[i];
      tick();
      checks += 2;
      if (out0 !== exp[i]) begin
        failures++;
        $display("FAIL min_out0 idx=%0d got=%h exp=%h", i, out0, exp[i]);
      end
      if (window_end !== we[i]) begin
        failures++;
        $display("FAIL min_we idx=%0d got=%b exp=%b", i, window_end, we[i]);
      end
    end
    running = 1'b0;
  endtask

  task automatic test_sat_sum();
    // Rows: restart flag, signed, stride, sample, expected out0, expected windowEnd.
    logic       rs  [7];
    logic       sg  [7];
    logic [6:0] st  [7];
    logic [7:0] smp [7];
    logic [7:0] exp [7];
    logic       we  [7];
    rs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    sg  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    st  = '{7'd2, 7'd2, 7'd2, 7'd1, 7'd1, 7'd1, 7'd1};
    smp = '{8'd100, 8'd100, 8'hCE, 8'd200, 8'd100, 8'h9C, 8'h9C};
    exp = '{8'd100, 8'h7F, 8'd77, 8'd200, 8'hFF, 8'h9C, 8'h80};
    we  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      if (rs[i]) start(2'b10, sg[i], st[i], 7'd0);
      running = 1'b1;
      in0     = smp[i];
      tick();
      checks += 2;
      if (out0 !== exp[i]) begin
        failures++;
        $display("FAIL sum_out0 idx=%0d got=%h exp=%h", i, out0, exp[i]);
      end
      if (window_end !== we[i]) begin
        failures++;
        $display("FAIL sum_we idx=%0d got=%b exp=%b", i, window_end, we[i]);
      end
    end
    running = 1'b0;
  endtask

  task automatic test_restart();
    logic [7:0] smp [4];
    logic [7:0] exp [4];
    logic       we  [4];
    smp = '{8'd50, 8'd30, 8'd40, 8'd60};
    exp = '{8'd50, 8'd30, 8'd30, 8'd30};
    we  = '{1'b0, 1'b0, 1'b0, 1'b1};
    start(2'b00, 1'b1, 7'd3, 7'd0);
    running = 1'b1;
    in0     = 8'd10;
    tick();
    in0 = 8'd20;
    tick();
    // Restart mid-window with running still high; run must win.
    run = 1'b1;
    op  = 2'b01;
    in0 = 8'd99;
    tick();
    run = 1'b0;
    checks++;
    if (out0 !== 8'd20 || window_end !== 1'b0) begin
      failures++;
      $display("FAIL restart_edge got=%h/%b exp=14/0", out0, window_end);
    end
    op = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in0 = smp[i];
      tick();
      checks += 2;
      if (out0 !== exp[i]) begin
        failures++;
        $display("FAIL restart_out0 idx=%0d got=%h exp=%h", i, out0, exp[i]);
      end
      if (window_end !== we[i]) begin
        failures++;
        $display("FAIL restart_we idx=%0d got=%b exp=%b", i, window_end, we[i]);
      end
    end
    running = 1'b0;
  endtask

  task automatic test_stride0_idle();
    start(2'b10, 1'b0, 7'd0, 7'd0);
    running = 1'b1;
    in0     = 8'd3;
    tick();
    checks++;
    if (out0 !== 8'd3 || window_end !== 1'b1) begin
      failures++;
      $display("FAIL stride0_a got=%h/%b exp=03/1", out0, window_end);
    end
    in0 = 8'd7;
    tick();
    checks++;
    if (out0 !== 8'd7 || window_end !== 1'b1) begin
      failures++;
      $display("FAIL stride0_b got=%h/%b exp=07/1", out0, window_end);
    end
    running = 1'b0;
    in0     = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out0 !== 8'd7 || window_end !== 1'b0) begin
        failures++;
        $display("FAIL idle_after idx=%0d got=%h/%b exp=07/0", i, out0, window_end);
      end
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] o, input logic s);
    int ia;
    int ib;
    int r;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    case (o)
      2'b01: r = (ia < ib) ? ia : ib;
      2'b10: begin
        r = ia + ib;
        if (s) begin
          if (r > 127) r = 127;
          if (r < -128) r = -128;
        end else if (r > 255) begin
          r = 255;
        end
      end
      default: r = (ia > ib) ? ia : ib;
    endcase
    return r[7:0];
  endfunction

  task automatic test_sweep();
    logic [7:0] m_acc;
    logic       m_we;
    int         m_dcnt;
    int         m_wcnt;
    int         cfg;
    logic [6:0] st;
    m_acc = 8'd7;
    cfg   = 0;
    for (int d = 0; d < 4; d++) begin
      for (int si = 0; si < 2; si++) begin
        for (int o = 0; o < 4; o++) begin
          for (int s = 0; s < 2; s++) begin
            st = (si == 0) ? 7'd0 : 7'd3;
            start(2'(o), 1'(s), st, 7'(d));
            m_dcnt = d;
            m_wcnt = 0;
            for (int i = 0; i < 256 + d; i++) begin
              if (cfg == 13 && i == 100) begin
                rst = 1'b1;
                #1;
                checks++;
                if (out0 !== 8'h00 || window_end !== 1'b0) begin
                  failures++;
                  $display("FAIL async_rst got=%h/%b exp=00/0", out0, window_end);
                end
                running = 1'b0;
                tick();
                rst   = 1'b0;
                m_acc = 8'h00;
                break;
              end
              running = 1'b1;
              in0     = 8'(i);
              if (m_dcnt != 0) begin
                m_dcnt--;
                m_we = 1'b0;
              end else begin
                m_acc  = (m_wcnt == 0) ? in0 : ref_op(m_acc, in0, 2'(o), 1'(s));
                m_we   = (m_wcnt == int'(st));
                m_wcnt = m_we ? 0 : m_wcnt + 1;
              end
              tick();
              checks += 2;
              if (out0 !== m_acc) begin
                failures++;
                $display("FAIL sweep_out0 d=%0d st=%0d op=%0d s=%0d i=%0d got=%h exp=%h",
                         d, st, o, s, i, out0, m_acc);
              end
              if (window_end !== m_we) begin
                failures++;
                $display("FAIL sweep_we d=%0d st=%0d op=%0d s=%0d i=%0d got=%b exp=%b",
                         d, st, o, s, i, window_end, m_we);
              end
            end
            running = 1'b0;
            cfg++;
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed_max();
    test_unsigned_min_delay();
    test_sat_sum();
    test_restart();
    test_stride0_idle();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f_accum_reduce.md
Name: f_accum_reduce

Overview:
- Configurable windowed reduction functional unit for the Versat datapath; successor to the max-only accumulator.
- Reduces a stream on in0 using signed/unsigned max, min, or saturating sum over windows of strideMinusOne+1 samples (e.g. max-pool, min-pool, avg-pool numerator).
- Delay counter aligns the first sample with upstream pipeline latency.
- Flags the last sample of each window so downstream units can capture completed results.

Parameters:
- DATA_W, 8, width of in0 and out0.
- DELAY_W, 7, width of delay0 and of the internal delay counter.
- STRIDE_W, 7, width of strideMinusOne and of the internal window counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  single-cycle start pulse; captures configuration.
- running  in  1  high while the accelerator is active.
- op  in  2  00=max, 01=min, 10=sum (saturating), 11=reserved (treated as max).
- isSigned  in  1  1 = two's-complement compare/saturate; 0 = unsigned.
- strideMinusOne  in  STRIDE_W  window length minus one.
- delay0  in  DELAY_W  number of running cycles to skip after run before the first sample.
- in0  in  DATA_W  input sample.
- out0  out  DATA_W  registered running reduction of the current window.
- windowEnd  out  1  registered; high for one cycle when out0 holds a completed window result.

Behaviour:
- Reset (async, rst=1): out0=0, windowEnd=0, delayCnt=0, winCnt=0, and captured op/isSigned/stride registers =0. Deassertion is taken synchronously at the next edge.
- Run edge (run=1):
  - Capture op, isSigned, strideMinusOne into shadow registers; load delayCnt=delay0; clear winCnt=0; windowEnd=0.
  - No sample is taken on this edge, and out0 holds.
  - run has priority over running in the same cycle. A run during an active operation restarts cleanly and discards any partial window.
- Delay phase (running=1 and delayCnt!=0): decrement delayCnt; no sample; out0 and windowEnd hold/clear (windowEnd=0).
- Sample phase (running=1 and delayCnt==0), one sample per cycle:
  - first = (winCnt==0).
  - acc_next = first ? in0 : f(out0, in0).
  - f is chosen by op: max or min compare (signedness per isSigned), or sum.
  - Sum: compute in DATA_W+1 bits; clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when signed, or [0, 2^DATA_W-1] when unsigned.
  - out0 <= acc_next. Latency is 1 cycle from a sample edge to out0.
  - windowEnd <= (winCnt==strideMin1_q).
  - winCnt <= (winCnt==strideMin1_q) ? 0 : winCnt+1.
- Idle (running=0, run=0): all state holds; windowEnd <= 0.
- strideMinusOne=0: every sample is its own window. out0 = in0 delayed by 1 cycle, and windowEnd=1 on every sample.
- Max strideMinusOne: winCnt wraps from 2^STRIDE_W-1 to 0 with no overflow.
- Configuration inputs are ignored except on the run edge.
- Reset mid-operation: immediate return to reset values. A new run is required before further sampling.

Decomposition:
- Shared package versat_accum_pkg holds:
  - op encodings OP_MAX, OP_MIN, OP_SUM as localparams;
  - a function sat_add(a, b, isSigned) parametrised by DATA_W.
- One natural sub-module: accum_reduce_alu, purely combinational (out0, in0, op, isSigned, first -> acc_next).
- The top level holds the counters, shadow registers, and output registers.

Test Plan:
- Reset/idle: rst pulse with random inputs -> out0=0, windowEnd=0; with run=0 and running=0 held, out0 stays 0 for 10 cycles.
- Signed max, window 4 (strideMinusOne=3, delay0=0, DATA_W=8):
  - Samples 5, -3, 7, 2, -8, -1, -9, -2 -> out0 sequence 5, 5, 7, 7, -8, -1, -1, -1.
  - windowEnd high after the 4th and 8th samples.
- Unsigned min with delay (op=01, delay0=2, strideMinusOne=1):
  - in0 0xF0, 0xE0 during the delay cycles are ignored.
  - Then 0x10, 0x80, 0xFF, 0x01 -> out0 0x10, 0x10, 0xFF, 0x01.
- Saturating sum:
  - Signed, window 3: 100, 100, -50 -> out0 100, 127, 77.
  - Unsigned: 200, 100 -> out0 200, 255.
- Restart/priority:
  - Assert run with running=1 mid-window (winCnt=2); the next sample starts a fresh window with out0=in0.
  - The op changed on that run takes effect; the op changed without run has no effect.
- Exhaustive sweep: for every delay0 in 0..3 and strideMinusOne in {0, 3}, stream in0=0..255 in each mode.
  - Compare out0 and windowEnd to a reference model every cycle.
  - Assert rst mid-stream once -> outputs are 0 on the same cycle (asynchronous).
